mdu_unit: RTL
=============

// Module: mdu_unit
// PURPOSE
//   Multi-cycle multiply/divide unit in the EX stage, alongside the ALU. It executes
//   mult/multu/div/divu and mthi/mtlo. HI/LO feed the MD operand latched by the
//   EX/MEM register, which carries mfhi/mflo results. Busy and start drive the
//   hazard unit's stall on md-class instructions.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//   clk     in   1   clock, rising edge
//   rst     in   1   asynchronous reset, active-low (0 = reset)
//   start   in   1   one-cycle pulse: launch the operation given by op
//   op      in   3   MD_MULT/MD_MULTU/MD_DIV/MD_DIVU/MD_MTHI/MD_MTLO/MD_NONE
//   A       in   32  rs operand (forwarded value)
//   B       in   32  rt operand (forwarded value)
//   req     in   1   exception/interrupt request; cancels this cycle's start
//   rd_sel  in   1   0 = MD from LO, 1 = MD from HI (mflo/mfhi)
//   busy    out  1   operation in flight
//   HI      out  32  HI register
//   LO      out  32  LO register
//   MD      out  32  combinational rd_sel ? HI : LO
// BEHAVIOUR
//   Reset (rst=0, asynchronous): HI=0, LO=0, cnt=0, busy=0, tmp_hi=0, tmp_lo=0.
//   Accept condition: an edge with start=1, req=0, busy=0 and op!=MD_NONE.
//     The edge is ignored if req=1 or busy=1. Ignored means no state change.
//   MD_MTHI / MD_MTLO: HI<=A or LO<=A at the accepting edge. No busy cycles.
//   MD_MULT: {tmp_hi,tmp_lo} <= $signed(A)*$signed(B), full 64-bit result; cnt<=MULT_CYCLES.
//   MD_MULTU: same operation, operands treated as unsigned.
//   MD_DIV: tmp_lo<=quotient, tmp_hi<=remainder; cnt<=DIV_CYCLES.
//     Signed division truncates toward zero. The remainder takes the sign of A.
//     0x80000000 / -1 gives LO=0x80000000 and HI=0.
//   MD_DIVU: as MD_DIV, operands treated as unsigned.
//   Divide by zero (B=0): cnt is still loaded. At completion HI and LO stay unchanged.
//   busy = (cnt != 0), taken from a register with no combinational path from start.
//     busy is high exactly N cycles after the accepting edge.
//   While cnt != 0: cnt decrements each edge.
//     The edge where cnt goes 1->0 commits HI<=tmp_hi and LO<=tmp_lo.
//     HI/LO show the new result in the same cycle busy falls.
//   During busy, HI/LO hold their old values. An mfhi/mflo issued then is stalled by the hazard unit.
//   req during busy does not abort the in-flight operation, which belongs to an
//     older committed instruction. req only blocks a new start.
//   Reset mid-operation: the operation is lost; all state returns to reset values.
//   MD is combinational from HI/LO and rd_sel, with zero latency.
// STRUCTURE
//   Shared const.v holds the MD_* op encodings (3-bit) and the mfhi/mflo rd_sel values.
//   The same header is used by the decoder and the hazard unit.
//   There is one counter FSM: IDLE (cnt=0) and RUN (cnt>0); no sub-module.
//   Multiply and divide results are computed with behavioural * / % at the accepting edge.
//   The cycle count models latency only.
// TESTING
//   1. mult with A=0xFFFFFFFE (-2), B=3.
//      busy is high for 5 cycles; afterwards HI=0xFFFFFFFF and LO=0xFFFFFFFA.
//   2. multu with A=0xFFFFFFFF, B=2.
//      Afterwards HI=0x00000001 and LO=0xFFFFFFFE.
//   3. div with A=-7, B=2.
//      busy is high for 10 cycles; afterwards LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1).
//   4. divu with A=7, B=0, starting from HI=0x11, LO=0x22.
//      busy is high for 10 cycles; HI=0x11 and LO=0x22 are unchanged.
//   5. mthi with A=0x1234 and req=1.
//      HI is unchanged and busy stays 0.
//      Repeat with req=0: HI=0x1234 on the next cycle; rd_sel=1 gives MD=0x1234.
//   6. Start mult, then pulse start=1 (div) at cycle 2, then drop rst at cycle 3.
//      The second start is ignored. After rst: busy=0, HI=0, LO=0 immediately without a clock edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
//   md_op_e    - 3-bit MD operation codes (also used by decode and hazard logic)
//   RD_LO/HI   - rd_sel values for mflo/mfhi
//   md_state_e - counter FSM states
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers.
//   clk, rst (async, active-low)
//   start/op/A/B : launch request; req cancels this cycle's start
//   rd_sel       : MD selects HI (1) or LO (0)
//   busy         : operation in flight (registered)
//   HI, LO, MD   : result registers and combinational read mux
// Results are computed at the accepting edge and parked in tmp_hi/tmp_lo;
// the cycle counter only models latency before they are committed.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  md_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_tmp_hi, r_tmp_lo;
  logic        r_dz;

  logic        w_signed;
  logic        w_neg_a, w_neg_b;
  logic [31:0] w_mag_a, w_mag_b, w_div_b;
  logic [31:0] w_uq, w_ur, w_q, w_r;
  logic [63:0] w_prod_s, w_prod_u;
  logic        w_accept;

  assign w_accept = start && !req && (r_state == S_IDLE) && (op != MD_NONE);

  // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly
  // to 0x80000000 with remainder 0 instead of overflowing.
  assign w_signed = (op == MD_DIV);
  assign w_neg_a  = w_signed && A[31];
  assign w_neg_b  = w_signed && B[31];
  assign w_mag_a  = w_neg_a ? -A : A;
  assign w_mag_b  = w_neg_b ? -B : B;
  // Divide-by-zero result is discarded at commit; avoid dividing by zero.
  assign w_div_b  = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_uq     = w_mag_a / w_div_b;
  assign w_ur     = w_mag_a % w_div_b;
  assign w_q      = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
  assign w_r      = w_neg_a ? -w_ur : w_ur;   // remainder follows sign of A

  assign w_prod_s = 64'($signed(A)) * 64'($signed(B));
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_tmp_hi <= '0;
      r_tmp_lo <= '0;
      r_dz     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (md_op_e'(op))
              MD_MTHI: HI <= A;
              MD_MTLO: LO <= A;
              MD_MULT, MD_MULTU: begin
                {r_tmp_hi, r_tmp_lo} <= (op == MD_MULT) ? w_prod_s : w_prod_u;
                r_cnt   <= CW'(MULT_CYCLES);
                r_dz    <= 1'b0;
                r_state <= S_RUN;
              end
              MD_DIV, MD_DIVU: begin
                r_tmp_lo <= w_q;
                r_tmp_hi <= w_r;
                r_cnt    <= CW'(DIV_CYCLES);
                r_dz     <= (B == 32'd0);
                r_state  <= S_RUN;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_IDLE;
            if (!r_dz) begin
              HI <= r_tmp_hi;
              LO <= r_tmp_lo;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign MD   = (rd_sel == RD_HI) ? HI : LO;

endmodule
